// File: rtl/beam_sum4_if.sv
`default_nettype none
// ============================================================================
//  Module   : beam_sum4_if
//  Brief    : Bundle of control, RAM-read and result signals between the
//             beam_sum4 delay-and-sum stage and its surroundings (sampler
//             RAMs, run control and the direction-finding consumer).
//  Revision : 1.0 - initial release
// ============================================================================
interface beam_sum4_if #(
    parameter int AW  = 9,
    parameter int DLW = 5
);
    // Run control from the sampler
    logic           start;
    logic [DLW-1:0] delay0;
    logic [DLW-1:0] delay1;
    logic [DLW-1:0] delay2;
    logic [DLW-1:0] delay3;

    // Per-channel sample RAM read ports
    logic [AW-1:0]  r_addr0;
    logic [AW-1:0]  r_addr1;
    logic [AW-1:0]  r_addr2;
    logic [AW-1:0]  r_addr3;
    logic [7:0]     q0;
    logic [7:0]     q1;
    logic [7:0]     q2;
    logic [7:0]     q3;

    // Results and status
    logic [9:0]     beam;
    logic           beam_valid;
    logic [26:0]    energy;
    logic           busy;
    logic           done;

    // Environment side: drives control and RAM data, observes results
    modport master (
        output start, delay0, delay1, delay2, delay3,
        output q0, q1, q2, q3,
        input  r_addr0, r_addr1, r_addr2, r_addr3,
        input  beam, beam_valid, energy, busy, done
    );

    // Beamformer side
    modport slave (
        input  start, delay0, delay1, delay2, delay3,
        input  q0, q1, q2, q3,
        output r_addr0, r_addr1, r_addr2, r_addr3,
        output beam, beam_valid, energy, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/beam_sum4.sv
`default_nettype none
// ============================================================================
//  Module   : beam_sum4
//  Brief    : Four-channel delay-and-sum beamformer. On start, reads the four
//             channel sample RAMs at steering-delay-offset addresses, emits
//             the 4-channel sum per sample and accumulates the window energy
//             of the mid-scale-centred sum.
//  Revision : 1.0 - initial release
// ============================================================================
module beam_sum4 #(
    parameter int AW  = 9,
    parameter int DLW = 5
) (
    input  wire logic   clk,
    input  wire logic   reset,
    beam_sum4_if.slave  bus
);

    // Last sample index: every channel address n + delay stays below 2^AW.
    localparam logic [AW-1:0] c_n_last = AW'((2 ** AW) - (2 ** DLW));

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    logic            w_accept;
    logic            w_last;
    logic            w_busy;
    logic            w_done;

    logic [AW-1:0]   r_n;
    logic [AW-1:0]   w_n_inc;
    logic [DLW-1:0]  w_delay [4];
    logic [DLW-1:0]  r_dly   [4];
    logic [AW-1:0]   r_addr  [4];

    logic            r_q_valid;
    logic [9:0]      w_sum;
    logic [9:0]      r_beam;
    logic            r_beam_valid;

    logic signed [10:0] w_cent;
    logic signed [21:0] w_cent_x;
    logic signed [21:0] w_sq_s;
    logic [21:0]        w_sq;
    logic [26:0]        r_energy;

    assign w_delay[0] = bus.delay0;
    assign w_delay[1] = bus.delay1;
    assign w_delay[2] = bus.delay2;
    assign w_delay[3] = bus.delay3;

    assign w_n_inc = r_n + AW'(1);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and status decode; start is only looked at while idle
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        w_busy       = (r_state != S_IDLE);
        w_done       = (r_state == S_DONE);
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (r_n == c_n_last) begin
                    w_last       = 1'b1;
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Final sum is on beam and folds into energy this cycle
                if (r_beam_valid && !r_q_valid) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Sample index n of the address currently presented to the RAMs
    always_ff @(posedge clk) begin
        if (reset || w_accept || w_last) begin
            r_n <= '0;
        end else if (r_state == S_RUN) begin
            r_n <= w_n_inc;
        end
    end

    // Delay latch and registered per-channel read addresses (n + delay)
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 4; k++) begin
                r_dly[k]  <= '0;
                r_addr[k] <= '0;
            end
        end else if (w_accept) begin
            for (int k = 0; k < 4; k++) begin
                r_dly[k]  <= w_delay[k];
                r_addr[k] <= {{(AW-DLW){1'b0}}, w_delay[k]};
            end
        end else if (w_last) begin
            for (int k = 0; k < 4; k++) begin
                r_addr[k] <= '0;
            end
        end else if (r_state == S_RUN) begin
            for (int k = 0; k < 4; k++) begin
                r_addr[k] <= w_n_inc + {{(AW-DLW){1'b0}}, r_dly[k]};
            end
        end
    end

    // RAM read data is valid one cycle after each address issued in RUN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q_valid <= 1'b0;
        end else begin
            r_q_valid <= (r_state == S_RUN);
        end
    end

    assign w_sum = {2'b00, bus.q0} + {2'b00, bus.q1} + {2'b00, bus.q2} + {2'b00, bus.q3};

    // Beam sum register; holds its last value between runs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_beam       <= '0;
            r_beam_valid <= 1'b0;
        end else begin
            r_beam_valid <= r_q_valid;
            if (r_q_valid) begin
                r_beam <= w_sum;
            end
        end
    end

    // Offset-binary mid-scale of a 4-channel sum is 4*128 = 512
    assign w_cent   = $signed({1'b0, r_beam}) - 11'sd512;
    assign w_cent_x = 22'(w_cent);
    assign w_sq_s   = w_cent_x * w_cent_x;
    assign w_sq     = $unsigned(w_sq_s);

    // Energy accumulator: cleared on run acceptance, held after completion
    always_ff @(posedge clk) begin
        if (reset || w_accept) begin
            r_energy <= '0;
        end else if (r_beam_valid) begin
            r_energy <= r_energy + {5'b00000, w_sq};
        end
    end

    assign bus.r_addr0    = r_addr[0];
    assign bus.r_addr1    = r_addr[1];
    assign bus.r_addr2    = r_addr[2];
    assign bus.r_addr3    = r_addr[3];
    assign bus.beam       = r_beam;
    assign bus.beam_valid = r_beam_valid;
    assign bus.energy     = r_energy;
    assign bus.busy       = w_busy;
    assign bus.done       = w_done;

endmodule
`default_nettype wire

// File: tb/tb_beam_sum4.sv
`default_nettype none
// ============================================================================
//  Module   : tb_beam_sum4
//  Brief    : Self-checking bench for beam_sum4 with a synchronous RAM model
//             and a window-level reference model of beam and energy.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_beam_sum4;

    localparam int AW    = 9;
    localparam int DLW   = 5;
    localparam int NOUT  = 481;
    localparam int MAXC  = 1000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    beam_sum4_if #(.AW(AW), .DLW(DLW)) bus();

    beam_sum4 #(.AW(AW), .DLW(DLW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Channel sample RAMs: data appears one cycle after the address
    logic [7:0] mem [0:3][0:511];
    always @(posedge clk) begin
        bus.q0 <= mem[0][bus.r_addr0];
        bus.q1 <= mem[1][bus.r_addr1];
        bus.q2 <= mem[2][bus.r_addr2];
        bus.q3 <= mem[3][bus.r_addr3];
    end

    int n_pass  = 0;
    int n_total = 0;

    int dl [4];

    // Observations, indexed by cycle number relative to start acceptance
    logic [8:0]  obs_addr [0:3][1:MAXC];
    logic [9:0]  obs_beam [1:MAXC];
    logic        obs_bv   [1:MAXC];
    logic [26:0] obs_en   [1:MAXC];
    logic        obs_busy [1:MAXC];
    logic        obs_done [1:MAXC];

    // Reference: beam per sample index and running energy
    int     exp_beam [0:NOUT-1];
    longint exp_pref [0:NOUT-1];

    task automatic model_compute();
        longint acc = 0;
        for (int n = 0; n < NOUT; n++) begin
            int s = 0;
            for (int k = 0; k < 4; k++) s += int'(mem[k][n + dl[k]]);
            exp_beam[n] = s;
            acc += longint'((s - 512) * (s - 512));
            exp_pref[n] = acc;
        end
    endtask

    function automatic longint exp_energy_at(input int t);
        int idx;
        if (t < 4) return 0;
        idx = (t - 4 > NOUT - 1) ? NOUT - 1 : t - 4;
        return exp_pref[idx];
    endfunction

    task automatic fill_const(input logic [7:0] v);
        for (int k = 0; k < 4; k++)
            for (int a = 0; a < 512; a++) mem[k][a] = v;
    endtask

    task automatic fill_random();
        for (int k = 0; k < 4; k++)
            for (int a = 0; a < 512; a++) mem[k][a] = 8'($urandom);
    endtask

    task automatic set_delays(input int d0, input int d1, input int d2, input int d3);
        dl[0] = d0; dl[1] = d1; dl[2] = d2; dl[3] = d3;
    endtask

    // Start a run with dl[] and record ncyc cycles of outputs.
    task automatic run_capture(input int ncyc, input bit hold, input int pulse_at, input int rst_at);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.delay0 = 5'(dl[0]);
        bus.delay1 = 5'(dl[1]);
        bus.delay2 = 5'(dl[2]);
        bus.delay3 = 5'(dl[3]);
        @(posedge clk);
        for (int t = 1; t <= ncyc; t++) begin
            #1;
            obs_addr[0][t] = bus.r_addr0;
            obs_addr[1][t] = bus.r_addr1;
            obs_addr[2][t] = bus.r_addr2;
            obs_addr[3][t] = bus.r_addr3;
            obs_beam[t]    = bus.beam;
            obs_bv[t]      = bus.beam_valid;
            obs_en[t]      = bus.energy;
            obs_busy[t]    = bus.busy;
            obs_done[t]    = bus.done;
            @(negedge clk);
            reset = (t == rst_at);
            if (t == pulse_at) begin
                bus.start  = 1'b1;
                bus.delay0 = 5'(dl[0] + 7);
                bus.delay1 = 5'(dl[1] + 3);
                bus.delay2 = 5'(dl[2] + 11);
                bus.delay3 = 5'(dl[3] + 5);
            end else begin
                bus.start  = hold;
                bus.delay0 = 5'(dl[0]);
                bus.delay1 = 5'(dl[1]);
                bus.delay2 = 5'(dl[2]);
                bus.delay3 = 5'(dl[3]);
            end
            @(posedge clk);
        end
        @(negedge clk);
        bus.start = 1'b0;
        reset     = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.start = 1'b0;
        set_delays(0, 0, 0, 0);
        bus.delay0 = '0; bus.delay1 = '0; bus.delay2 = '0; bus.delay3 = '0;
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if ({bus.r_addr0, bus.r_addr1, bus.r_addr2, bus.r_addr3} !== 36'd0)
            $display("FAIL reset_addr: got %h expected 0", {bus.r_addr0, bus.r_addr1, bus.r_addr2, bus.r_addr3});
        else n_pass++;
        n_total++;
        if ({bus.beam, bus.beam_valid} !== 11'd0)
            $display("FAIL reset_beam: got %0d/%0d expected 0/0", bus.beam, bus.beam_valid);
        else n_pass++;
        n_total++;
        if (bus.energy !== 27'd0) $display("FAIL reset_energy: got %0d expected 0", bus.energy);
        else n_pass++;
        n_total++;
        if ({bus.busy, bus.done} !== 2'b00)
            $display("FAIL reset_status: got busy=%0d done=%0d expected 0/0", bus.busy, bus.done);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_const128();
        fill_const(8'd128);
        set_delays(0, 0, 0, 0);
        model_compute();
        run_capture(490, 1'b0, 0, 0);
        for (int t = 1; t <= 490; t++) begin
            n_total++;
            if (obs_bv[t] !== (t >= 3 && t <= 483))
                $display("FAIL c128_valid t=%0d: got %0d expected %0d", t, obs_bv[t], (t >= 3 && t <= 483));
            else n_pass++;
            if (t >= 3 && t <= 483) begin
                n_total++;
                if (obs_beam[t] !== 10'd512) $display("FAIL c128_beam t=%0d: got %0d expected 512", t, obs_beam[t]);
                else n_pass++;
            end
            n_total++;
            if (obs_done[t] !== (t == 484)) $display("FAIL c128_done t=%0d: got %0d expected %0d", t, obs_done[t], (t == 484));
            else n_pass++;
            n_total++;
            if (obs_busy[t] !== (t <= 484)) $display("FAIL c128_busy t=%0d: got %0d expected %0d", t, obs_busy[t], (t <= 484));
            else n_pass++;
            n_total++;
            if (obs_en[t] !== 27'd0) $display("FAIL c128_energy t=%0d: got %0d expected 0", t, obs_en[t]);
            else n_pass++;
            if (t <= NOUT) begin
                n_total++;
                if (obs_addr[0][t] !== 9'(t - 1)) $display("FAIL c128_addr t=%0d: got %0d expected %0d", t, obs_addr[0][t], t - 1);
                else n_pass++;
            end
        end
    endtask

    task automatic test_ramp_delays();
        for (int k = 0; k < 4; k++)
            for (int a = 0; a < 512; a++) mem[k][a] = 8'(a);
        set_delays(0, 1, 2, 3);
        model_compute();
        run_capture(486, 1'b0, 0, 0);
        n_total++;
        if (obs_beam[3] !== 10'd6) $display("FAIL ramp_beam_n0: got %0d expected 6", obs_beam[3]);
        else n_pass++;
        n_total++;
        if (obs_beam[13] !== 10'd46) $display("FAIL ramp_beam_n10: got %0d expected 46", obs_beam[13]);
        else n_pass++;
        for (int t = 1; t <= NOUT; t++) begin
            n_total++;
            if (obs_addr[3][t] !== 9'(t + 2)) $display("FAIL ramp_addr3 t=%0d: got %0d expected %0d", t, obs_addr[3][t], t + 2);
            else n_pass++;
        end
        n_total++;
        if (obs_en[484] !== 27'(exp_pref[NOUT-1]))
            $display("FAIL ramp_energy: got %0d expected %0d", obs_en[484], exp_pref[NOUT-1]);
        else n_pass++;
    endtask

    task automatic test_full_scale();
        for (int pass = 0; pass < 2; pass++) begin
            logic [7:0]  v     = (pass == 0) ? 8'd255 : 8'd0;
            logic [9:0]  b_exp = (pass == 0) ? 10'd1020 : 10'd0;
            logic [26:0] e_exp = (pass == 0) ? 27'd124128784 : 27'd126091264;
            fill_const(v);
            set_delays(0, 0, 0, 0);
            run_capture(486, 1'b0, 0, 0);
            for (int t = 3; t <= 483; t++) begin
                n_total++;
                if (obs_beam[t] !== b_exp) $display("FAIL fs_beam v=%0d t=%0d: got %0d expected %0d", v, t, obs_beam[t], b_exp);
                else n_pass++;
            end
            n_total++;
            if (obs_en[484] !== e_exp) $display("FAIL fs_energy v=%0d: got %0d expected %0d", v, obs_en[484], e_exp);
            else n_pass++;
            n_total++;
            if (obs_en[486] !== e_exp) $display("FAIL fs_energy_hold v=%0d: got %0d expected %0d", v, obs_en[486], e_exp);
            else n_pass++;
        end
    endtask

    task automatic test_delay_extremes();
        fill_random();
        set_delays(31, 31, 31, 31);
        run_capture(486, 1'b0, 0, 0);
        n_total++;
        if (obs_addr[0][1] !== 9'd31) $display("FAIL dmax_first: got %0d expected 31", obs_addr[0][1]);
        else n_pass++;
        n_total++;
        if (obs_addr[2][NOUT] !== 9'd511) $display("FAIL dmax_last: got %0d expected 511", obs_addr[2][NOUT]);
        else n_pass++;
        for (int t = 1; t <= NOUT; t++) begin
            n_total++;
            if (obs_addr[1][t] !== 9'(t + 30)) $display("FAIL dmax_addr t=%0d: got %0d expected %0d", t, obs_addr[1][t], t + 30);
            else n_pass++;
        end
        set_delays(0, 31, 0, 31);
        run_capture(486, 1'b0, 0, 0);
        for (int t = 1; t <= NOUT; t++) begin
            n_total++;
            if (int'(obs_addr[1][t]) - int'(obs_addr[0][t]) !== 31)
                $display("FAIL dmix_diff t=%0d: got %0d expected 31", t, int'(obs_addr[1][t]) - int'(obs_addr[0][t]));
            else n_pass++;
        end
    endtask

    task automatic test_restart_ignored();
        fill_random();
        set_delays(int'($urandom_range(0, 20)), int'($urandom_range(0, 20)),
                   int'($urandom_range(0, 20)), int'($urandom_range(0, 20)));
        model_compute();
        run_capture(490, 1'b0, 200, 0);
        for (int t = 3; t <= 483; t++) begin
            n_total++;
            if (obs_beam[t] !== 10'(exp_beam[t-3])) $display("FAIL restart_beam t=%0d: got %0d expected %0d", t, obs_beam[t], exp_beam[t-3]);
            else n_pass++;
        end
        for (int t = 1; t <= 490; t++) begin
            n_total++;
            if (obs_done[t] !== (t == 484)) $display("FAIL restart_done t=%0d: got %0d expected %0d", t, obs_done[t], (t == 484));
            else n_pass++;
        end
        n_total++;
        if (obs_en[490] !== 27'(exp_pref[NOUT-1])) $display("FAIL restart_energy: got %0d expected %0d", obs_en[490], exp_pref[NOUT-1]);
        else n_pass++;
    endtask

    task automatic test_reset_midrun();
        fill_random();
        set_delays(5, 9, 13, 17);
        run_capture(110, 1'b0, 0, 100);
        n_total++;
        if (obs_busy[100] !== 1'b1) $display("FAIL rst_busy_before: got %0d expected 1", obs_busy[100]);
        else n_pass++;
        n_total++;
        if ({obs_addr[0][101], obs_addr[1][101], obs_addr[2][101], obs_addr[3][101]} !== 36'd0)
            $display("FAIL rst_addr: got %0d expected 0", obs_addr[0][101]);
        else n_pass++;
        n_total++;
        if ({obs_beam[101], obs_bv[101], obs_en[101], obs_busy[101], obs_done[101]} !== 40'd0)
            $display("FAIL rst_outputs: got beam=%0d valid=%0d energy=%0d busy=%0d done=%0d expected all 0",
                     obs_beam[101], obs_bv[101], obs_en[101], obs_busy[101], obs_done[101]);
        else n_pass++;
        set_delays(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                   int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
        model_compute();
        run_capture(486, 1'b0, 0, 0);
        n_total++;
        if (obs_en[484] !== 27'(exp_pref[NOUT-1])) $display("FAIL rst_fresh_energy: got %0d expected %0d", obs_en[484], exp_pref[NOUT-1]);
        else n_pass++;
        n_total++;
        if (obs_done[484] !== 1'b1) $display("FAIL rst_fresh_done: got %0d expected 1", obs_done[484]);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int it = 0; it < 3; it++) begin
            fill_random();
            set_delays(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                       int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
            model_compute();
            run_capture(488, 1'b0, 0, 0);
            for (int t = 1; t <= 488; t++) begin
                if (t <= NOUT) begin
                    for (int k = 0; k < 4; k++) begin
                        n_total++;
                        if (obs_addr[k][t] !== 9'(t - 1 + dl[k]))
                            $display("FAIL rnd_addr%0d t=%0d: got %0d expected %0d", k, t, obs_addr[k][t], t - 1 + dl[k]);
                        else n_pass++;
                    end
                end
                n_total++;
                if (obs_bv[t] !== (t >= 3 && t <= 483)) $display("FAIL rnd_valid t=%0d: got %0d expected %0d", t, obs_bv[t], (t >= 3 && t <= 483));
                else n_pass++;
                if (t >= 3 && t <= 483) begin
                    n_total++;
                    if (obs_beam[t] !== 10'(exp_beam[t-3])) $display("FAIL rnd_beam t=%0d: got %0d expected %0d", t, obs_beam[t], exp_beam[t-3]);
                    else n_pass++;
                end
                n_total++;
                if (obs_en[t] !== 27'(exp_energy_at(t))) $display("FAIL rnd_energy t=%0d: got %0d expected %0d", t, obs_en[t], exp_energy_at(t));
                else n_pass++;
                n_total++;
                if (obs_done[t] !== (t == 484)) $display("FAIL rnd_done t=%0d: got %0d expected %0d", t, obs_done[t], (t == 484));
                else n_pass++;
            end
        end
    endtask

    task automatic test_start_held();
        fill_random();
        set_delays(int'($urandom_range(1, 31)), int'($urandom_range(0, 31)),
                   int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
        model_compute();
        run_capture(975, 1'b1, 0, 0);
        for (int t = 1; t <= 975; t++) begin
            n_total++;
            if (obs_done[t] !== (t == 484 || t == 969))
                $display("FAIL held_done t=%0d: got %0d expected %0d", t, obs_done[t], (t == 484 || t == 969));
            else n_pass++;
        end
        n_total++;
        if (obs_busy[485] !== 1'b0) $display("FAIL held_idle485: got %0d expected 0", obs_busy[485]);
        else n_pass++;
        n_total++;
        if (obs_en[485] !== 27'(exp_pref[NOUT-1])) $display("FAIL held_energy485: got %0d expected %0d", obs_en[485], exp_pref[NOUT-1]);
        else n_pass++;
        n_total++;
        if (obs_en[486] !== 27'd0) $display("FAIL held_clear486: got %0d expected 0", obs_en[486]);
        else n_pass++;
        n_total++;
        if (obs_addr[0][486] !== 9'(dl[0])) $display("FAIL held_addr486: got %0d expected %0d", obs_addr[0][486], dl[0]);
        else n_pass++;
        n_total++;
        if (obs_en[969] !== 27'(exp_pref[NOUT-1])) $display("FAIL held_energy969: got %0d expected %0d", obs_en[969], exp_pref[NOUT-1]);
        else n_pass++;
    endtask

    initial begin
        bus.start = 1'b0;
        fill_const(8'd0);
        test_reset();
        test_const128();
        test_ramp_delays();
        test_full_scale();
        test_delay_extremes();
        test_restart_ignored();
        test_reset_midrun();
        test_random();
        test_start_held();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/beam_sum4.md
# beam_sum4

Delay-and-sum beamformer stage downstream of the 4-channel ADC sampler and its per-channel 8x512 sample RAMs. When the sampler signals that its capture is complete, this block reads the four channel buffers at independent, steering-delay-offset addresses. It produces a stream of 4-channel sums and accumulates the window energy of the mid-scale-centred sum. Per-steering-angle energy from this block drives direction finding downstream.

## Interface
- AW, 9, RAM address width (buffer depth 2^AW = 512)
- DLW, 5, steering-delay width (max delay 2^DLW-1 = 31 samples)
- clk  input  1  system clock; all logic rising-edge
- reset  input  1  synchronous, active-high; one clock, reset is synchronous and active-high
- start  input  1  level-sampled in IDLE; begins a run (driven from sampler doneWriting rising edge)
- delay0..delay3  input  DLW each  per-channel steering delay in samples; latched at start
- r_addr0..r_addr3  output  AW each  read address to channel k RAM
- q0..q3  input  8 each  RAM read data, unsigned offset-binary, valid 1 cycle after address
- beam  output  10  unsigned sum q0+q1+q2+q3 (0..1020)
- beam_valid  output  1  beam holds a new sample this cycle
- energy  output  27  unsigned sum over window of (beam-512)^2
- busy  output  1  state != IDLE
- done  output  1  one-cycle pulse; energy final and stable until next start

## Operation
- States: IDLE -> RUN -> DRAIN -> DONE -> IDLE.
- IDLE: r_addr* = 0, beam_valid = 0; start=1 latches delay0..3, clears energy to 0, clears index n, goes to RUN.
- RUN: r_addrk = n + delayk (registered), n = 0..NOUT-1, NOUT = 2^AW - 2^DLW + 1 = 481; after n = 480 -> DRAIN. Max address 480+31 = 511; no wrap possible.
- Stage 1: RAM returns q* for sample n. Stage 2: beam <= zero-extended 10-bit sum, beam_valid <= 1. Stage 3: c = beam - 512 (signed 11-bit, -512..508), energy <= energy + c*c (22-bit square, 27-bit accumulate, no overflow: max 481*512^2 = 126,091,264 < 2^27).
- DRAIN: wait until last sample accumulated -> DONE. DONE: done = 1 for one cycle -> IDLE.
- start ignored while busy. Delay inputs ignored except at the start-acceptance cycle.
- Reset (including mid-run): state IDLE; r_addr*, beam, beam_valid, energy, busy, done, n all 0 on the following cycle; pipeline contents discarded.

## Timing
- Cycle 0: start=1 sampled in IDLE.
- Cycles 1..481: r_addr for n = 0..480 (r_addr for n appears in cycle 1+n). busy=1, energy=0 from cycle 1.
- beam/beam_valid for sample n during cycle 3+n; beam_valid high cycles 3..483 contiguously, low otherwise.
- energy includes sample n from cycle 4+n; final at cycle 484.
- done=1 in cycle 484 only; busy high cycles 1..484, low at 485; start may be accepted in cycle 485.
- beam holds its last value when beam_valid=0. energy holds after done until the next start.

## Test plan
- RAM model returns 128 on all channels, delays 0,0,0,0 -> 481 beam_valid cycles (3..483) with beam=512; energy=0; done exactly at cycle 484.
- Channel k data = addr[7:0], delays 0,1,2,3 -> r_addr3 = n+3. beam at n=0 is 6, at n=10 is 46; energy matches a software model.
- All channels 255 -> beam=1020, energy=124,128,784. All channels 0 -> beam=0, energy=126,091,264; no overflow.
- Delays 31,31,31,31 -> first r_addr = 31, last r_addr = 511, never 0 after the first address. Delays 0,31,0,31 -> r_addr1 - r_addr0 = 31 throughout.
- start pulsed again at cycle 200 with different delays -> ignored; results identical to single run. reset at cycle 100 -> all outputs 0 at cycle 101, IDLE. A fresh start then completes with correct energy.
- start held high continuously -> second run accepted at cycle 485 with energy cleared at 486; done pulses at 484 and 969.
